// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RISC-V memory stage.
// funct3 load/store encodings, Writeback result-select encodings, and the
// wait-state FSM state type.
package riscv_mem_pkg;

  // Load encodings (RV32I)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (RV32I)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } memState_t;

endpackage

// File: rtl/data_mem_be.sv
// Data memory: DEPTH_WORDS x 32-bit words, byte-write-enabled.
// Ports:
//   clk    - clock; writes commit on the rising edge
//   byteEn - per-byte write enable (bit i writes wdata[8i+7:8i])
//   addr   - word index
//   wdata  - write data (already lane-replicated by the caller)
//   rdata  - combinational read of mem[addr]
// Contents are not affected by reset.
module data_mem_be #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [3:0]                     byteEn,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (byteEn[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_stage_be.sv
// Memory stage of the 5-stage RISC-V pipeline (between EX/M and Writeback).
// Byte/halfword/word load-store with sign/zero extension, misalignment
// detection, a MEM_LATENCY wait-state FSM driving stall_m, and the M/W
// pipeline register.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   valid_m, reg_write_m        - M-stage qualifiers
//   mem_read_m, mem_write_m     - load / store
//   result_src_m, funct3_m      - result select, access size/sign
//   alu_result_m, write_data_m  - address / ALU result, store data
//   pc_plus4_m, rd_m            - PC+4, destination register
//   stall_m                     - hold upstream stages (combinational)
//   *_w                         - registered Writeback outputs
//   misalign_w                  - previous M instruction was misaligned
module mem_stage_be
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  result_src_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [31:0] pc_plus4_m,
  input  logic [4:0]  rd_m,
  output logic        stall_m,
  output logic        valid_w,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w,
  output logic [31:0] read_data_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] pc_plus4_w,
  output logic [4:0]  rd_w,
  output logic        misalign_w
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  memState_t   state;
  logic [3:0]  cnt;
  logic        access;
  logic        misalignRaw;
  logic        misalign;
  logic        memWe;
  logic [AW-1:0] wordIdx;
  logic [1:0]  byteOff;
  logic [3:0]  storeEn;
  logic [3:0]  byteEn;
  logic [31:0] storeData;
  logic [31:0] rdWord;
  logic [31:0] loadData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:AW+2] unusedAddrHi;

  assign access       = valid_m & (mem_read_m | mem_write_m);
  assign wordIdx      = alu_result_m[AW+1:2];
  assign byteOff      = alu_result_m[1:0];
  // Address bits above the memory size are ignored, so accesses wrap.
  assign unusedAddrHi = alu_result_m[31:AW+2];

  always_comb begin
    misalignRaw = 1'b1;
    case (funct3_m)
      F3_LB, F3_LBU: misalignRaw = 1'b0;
      F3_LH, F3_LHU: misalignRaw = byteOff[0];
      F3_LW:         misalignRaw = (byteOff != 2'b00);
      default:       misalignRaw = 1'b1;
    endcase
    misalign = access & misalignRaw;
  end

  always_comb begin
    stall_m = 1'b0;
    if (state == ST_IDLE) stall_m = access && (LAT != 4'd0);
    else                  stall_m = (cnt != LAT);
  end

  always_comb begin
    storeEn   = 4'b0000;
    storeData = write_data_m;
    case (funct3_m)
      F3_SB: begin
        storeEn   = 4'b0001 << byteOff;
        storeData = {4{write_data_m[7:0]}};
      end
      F3_SH: begin
        storeEn   = 4'b0011 << {byteOff[1], 1'b0};
        storeData = {2{write_data_m[15:0]}};
      end
      F3_SW: storeEn = 4'b1111;
      default: storeEn = 4'b0000;
    endcase
  end

  // Commit only on the completion edge; rst also guards the final WAIT
  // cycle so an interrupted access never writes.
  assign memWe  = access & mem_write_m & ~misalign & ~stall_m & ~rst;
  assign byteEn = memWe ? storeEn : 4'b0000;

  data_mem_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uMem (
    .clk    (clk),
    .byteEn (byteEn),
    .addr   (wordIdx),
    .wdata  (storeData),
    .rdata  (rdWord)
  );

  always_comb begin
    loadByte = rdWord[{byteOff, 3'b000} +: 8];
    loadHalf = byteOff[1] ? rdWord[31:16] : rdWord[15:0];
    case (funct3_m)
      F3_LB:   loadData = {{24{loadByte[7]}}, loadByte};
      F3_LBU:  loadData = {24'h0, loadByte};
      F3_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
      F3_LHU:  loadData = {16'h0, loadHalf};
      default: loadData = rdWord;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && (LAT != 4'd0)) begin
            state <= ST_WAIT;
            cnt   <= 4'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == LAT) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stall_m || !valid_m) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      read_data_w  <= '0;
      alu_result_w <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
      misalign_w   <= 1'b0;
    end else begin
      valid_w      <= 1'b1;
      reg_write_w  <= reg_write_m & ~misalign;
      result_src_w <= result_src_m;
      read_data_w  <= loadData;
      alu_result_w <= alu_result_m;
      pc_plus4_w   <= pc_plus4_m;
      rd_w         <= rd_m;
      misalign_w   <= misalign;
    end
  end

endmodule
